// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Latency: accept -> EXEC (1 cycle, ALU inputs registered) -> RESP, so rsp_valid is seen 2 cycles after req_ready.
// Backpressure: one op in flight; RESP holds until the owner's rsp_ready, and no request is accepted before then.
//
// Ports: req_*_0/1 request channels (valid/ready, op, a, b); rsp_*_0/1 response channels sharing rsp_result;
//        alu_ctrl/alu_src_a/alu_src_b drive the ALU, alu_result returns from it; busy = not IDLE.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid_0,
    input  logic             req_valid_1,
    output logic             req_ready_0,
    output logic             req_ready_1,
    input  logic [OPW-1:0]   req_op_0,
    input  logic [OPW-1:0]   req_op_1,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_0,
    input  logic [WIDTH-1:0] req_b_1,
    output logic             rsp_valid_0,
    output logic             rsp_valid_1,
    input  logic             rsp_ready_0,
    input  logic             rsp_ready_1,
    output logic [WIDTH-1:0] rsp_result,
    output logic [OPW-1:0]   alu_ctrl,
    output logic [WIDTH-1:0] alu_src_a,
    output logic [WIDTH-1:0] alu_src_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [OPW-1:0]   alu_ctrl_q, alu_ctrl_d;
    logic [WIDTH-1:0] src_a_q, src_a_d;
    logic [WIDTH-1:0] src_b_q, src_b_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;

    logic gnt_0, gnt_1;
    logic accept;
    logic rsp_hs;

    // Under contention the requester that did not win last time is granted;
    // last_grant resets to 1 so requester 0 wins the first contest.
    always_comb begin
        gnt_0 = req_valid_0 && (!req_valid_1 || last_grant_q);
        gnt_1 = req_valid_1 && (!req_valid_0 || !last_grant_q);
    end

    // resetn gates ready so nothing looks accepted while reset is held.
    assign req_ready_0 = resetn && (state_q == IDLE) && gnt_0;
    assign req_ready_1 = resetn && (state_q == IDLE) && gnt_1;
    assign accept      = req_ready_0 || req_ready_1;
    // Only the owner's rsp_ready completes the response.
    assign rsp_hs      = (state_q == RESP) && (owner_q ? rsp_ready_1 : rsp_ready_0);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        alu_ctrl_d   = alu_ctrl_q;
        src_a_d      = src_a_q;
        src_b_d      = src_b_q;
        rsp_result_d = rsp_result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = EXEC;
                    owner_d      = gnt_1;
                    last_grant_d = gnt_1;
                    alu_ctrl_d   = gnt_1 ? req_op_1 : req_op_0;
                    src_a_d      = gnt_1 ? req_a_1  : req_a_0;
                    src_b_d      = gnt_1 ? req_b_1  : req_b_0;
                end
            end
            EXEC: begin
                // ALU inputs have been stable for a full cycle; capture its output.
                rsp_result_d = alu_result;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            alu_ctrl_q   <= '0;
            src_a_q      <= '0;
            src_b_q      <= '0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            alu_ctrl_q   <= alu_ctrl_d;
            src_a_q      <= src_a_d;
            src_b_q      <= src_b_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign alu_ctrl    = alu_ctrl_q;
    assign alu_src_a   = src_a_q;
    assign alu_src_b   = src_b_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_valid_0 = (state_q == RESP) && !owner_q;
    assign rsp_valid_1 = (state_q == RESP) && owner_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus randomized traffic against a reference model.
// Latency expected: ready seen in cycle c, response visible in cycle c+2.
// Backpressure exercised by holding rsp_ready low while another requester waits.
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int OPW   = 4;

    // ALU opcode map used by the stand-in ALU below.
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                           OP_XOR = 4'h4, OP_LTS = 4'h5, OP_LTU = 4'h6, OP_LS  = 4'h7,
                           OP_RS  = 4'h8, OP_RSA = 4'h9;

    logic             clk = 1'b0;
    logic             resetn;
    logic             req_valid_0, req_valid_1, req_ready_0, req_ready_1;
    logic [OPW-1:0]   req_op_0, req_op_1;
    logic [WIDTH-1:0] req_a_0, req_a_1, req_b_0, req_b_1;
    logic             rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
    logic [WIDTH-1:0] rsp_result;
    logic [OPW-1:0]   alu_ctrl;
    logic [WIDTH-1:0] alu_src_a, alu_src_b, alu_result;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;
    int prev_win = 1;   // model: requester granted on the previous accept

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_op_0(req_op_0), .req_op_1(req_op_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
        .rsp_result(rsp_result),
        .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_result(alu_result), .busy(busy)
    );

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_LTS:  return {31'd0, $signed(a) < $signed(b)};
            OP_LTU:  return {31'd0, a < b};
            OP_LS:   return a << b[4:0];
            OP_RS:   return a >> b[4:0];
            OP_RSA:  return $signed(a) >>> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // Combinational ALU stand-in.
    always_comb alu_result = alu_ref(alu_ctrl, alu_src_a, alu_src_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present the given valids for one cycle, verify the grant against the model,
    // then verify the ALU inputs registered from the winner. Called at posedge+1.
    task automatic issue(input logic v0, input logic v1,
                         input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                         output int win);
        int exp_win;
        req_valid_0 = v0; req_op_0 = op0; req_a_0 = a0; req_b_0 = b0;
        req_valid_1 = v1; req_op_1 = op1; req_a_1 = a1; req_b_1 = b1;
        exp_win = (v0 && v1) ? 1 - prev_win : (v0 ? 0 : 1);
        #1;
        check("req_ready_0", {31'd0, req_ready_0}, {31'd0, exp_win == 0});
        check("req_ready_1", {31'd0, req_ready_1}, {31'd0, exp_win == 1});
        check("busy_idle", {31'd0, busy}, 32'd0);
        prev_win = exp_win;
        win = exp_win;
        @(posedge clk); #1;
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        check("busy_exec", {31'd0, busy}, 32'd1);
        check("rsp_valid_exec", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
        check("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, win ? op1 : op0});
        check("alu_src_a", alu_src_a, win ? a1 : a0);
        check("alu_src_b", alu_src_b, win ? b1 : b0);
    endtask

    // Check the response phase; hold rsp_ready low for 'hold' cycles first.
    // With 'pressure' set, requester 1 is assumed to be waiting and must see no ready.
    task automatic complete(input int win, input logic [31:0] exp_res, input int hold, input bit pressure);
        @(posedge clk); #1;
        // The non-owner's rsp_ready is raised throughout and must be ignored.
        if (win == 0) rsp_ready_1 = 1'b1; else rsp_ready_0 = 1'b1;
        check("rsp_valid_owner", {30'd0, rsp_valid_1, rsp_valid_0}, win ? 32'd2 : 32'd1);
        check("rsp_result", rsp_result, exp_res);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("rsp_valid_hold", {30'd0, rsp_valid_1, rsp_valid_0}, win ? 32'd2 : 32'd1);
            check("rsp_result_hold", rsp_result, exp_res);
            if (pressure) check("req_ready_1_blocked", {31'd0, req_ready_1}, 32'd0);
        end
        if (win == 0) rsp_ready_0 = 1'b1; else rsp_ready_1 = 1'b1;
        @(posedge clk); #1;
        rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
        check("rsp_valid_done", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
        check("busy_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int w;
        logic [3:0]  op0, op1;
        logic [31:0] a0, a1, b0, b1;

        // Reset state, with both valids high to confirm ready stays low in reset.
        resetn = 1'b0;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        req_op_0 = '0; req_op_1 = '0; req_a_0 = '0; req_a_1 = '0; req_b_0 = '0; req_b_1 = '0;
        rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {30'd0, req_ready_1, req_ready_0}, 32'd0);
        check("rst_rsp_valid", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        check("rst_src_a", alu_src_a, 32'd0);
        check("rst_src_b", alu_src_b, 32'd0);
        check("rst_result", rsp_result, 32'd0);
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Single add on requester 0.
        issue(1, 0, OP_ADD, 5, 7, 0, 0, 0, w);
        complete(w, 32'd12, 0, 0);

        // Wraparound subtract on requester 1.
        issue(0, 1, 0, 0, 0, OP_SUB, 3, 5, w);
        complete(w, 32'hFFFF_FFFE, 0, 0);

        // Contention: last grant was 1, so 0 wins, then 1.
        issue(1, 1, OP_SUB, 10, 4, OP_LS, 1, 4, w);
        check("contest_first", w, 0);
        complete(w, 32'd6, 0, 0);
        issue(1, 1, OP_SUB, 10, 4, OP_LS, 1, 4, w);
        complete(w, 32'd16, 0, 0);

        // Eight back-to-back contested ops alternate strictly.
        for (int i = 0; i < 8; i++) begin
            a0 = 32'd100 + i; b0 = 32'd3; a1 = 32'd7; b1 = i;
            issue(1, 1, OP_ADD, a0, b0, OP_LS, a1, b1, w);
            check("alternation", w, i % 2);
            complete(w, w ? alu_ref(OP_LS, a1, b1) : alu_ref(OP_ADD, a0, b0), 0, 0);
        end

        // Backpressure: requester 0 holds off its response while requester 1 waits.
        issue(1, 0, OP_LTS, 32'hFFFF_FFFF, 0, 0, 0, 0, w);
        req_valid_1 = 1'b1; req_op_1 = OP_OR; req_a_1 = 32'h0F0; req_b_1 = 32'h00F;
        check("req_ready_1_exec", {31'd0, req_ready_1}, 32'd0);
        complete(w, 32'd1, 5, 1);
        issue(0, 1, 0, 0, 0, OP_OR, 32'h0F0, 32'h00F, w);
        complete(w, 32'h0FF, 0, 0);

        // Reset during EXEC discards the op.
        issue(1, 0, OP_ADD, 1, 1, 0, 0, 0, w);
        #1;
        resetn = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_src_a", alu_src_a, 32'd0);
        check("midrst_rsp_valid", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        prev_win = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midrst_no_rsp", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
        end
        issue(0, 1, OP_ADD, 0, 0, OP_ADD, 2, 3, w);
        complete(w, 32'd5, 0, 0);
        issue(1, 1, OP_XOR, 32'hFF, 32'h0F, OP_AND, 32'hFF, 32'h0F, w);
        check("postrst_contest", w, 0);
        complete(w, 32'hF0, 0, 0);

        // Undefined opcode returns 0; the next op is unaffected.
        issue(0, 1, 0, 0, 0, 4'hF, 9, 9, w);
        complete(w, 32'd0, 0, 0);
        issue(0, 1, 0, 0, 0, OP_ADD, 9, 9, w);
        complete(w, 32'd18, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 60; i++) begin
            int sel;
            int hold;
            sel  = $urandom_range(1, 3);
            hold = $urandom_range(0, 3);
            op0 = 4'($urandom_range(0, 15)); op1 = 4'($urandom_range(0, 15));
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            if (i % 4 == 0) begin
                a0 = $urandom_range(0, 8); b0 = $urandom_range(0, 8);
            end
            issue(sel[0], sel[1], op0, a0, b0, op1, a1, b1, w);
            complete(w, w ? alu_ref(op1, a1, b1) : alu_ref(op0, a0, b0), hold, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
